digital_project: RTL and testbench
==================================

Name: digital_project

Overview:
- Projection front end feeding the digit recogniser. Analyses a monochrome video stream and locates the bounding rows and columns of dark digit glyphs.
- Row projection runs on frame 0 and column projection on frame 1. Results go to the row/column border RAMs as {low/left, high/right} pairs.
- Publishes `num_row`, `num_col`, `frame_cnt` and `project_done_flag`. The recogniser consumes these during frame 2.

Parameters:
- NUM_ROW, 1, max digit rows recorded (≤15)
- NUM_COL, 7, max digit columns recorded (≤15)
- H_PIXEL, 1024, pixels per line (`ypos` range)
- V_PIXEL, 768, lines per frame (`xpos` range)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms projection from IDLE
- frame_de  in  1  active-pixel qualifier
- monoc  in  1  binarised pixel; 0 = foreground (digit), 1 = background
- xpos  in  11  current line index (vertical)
- ypos  in  11  current pixel index within line (horizontal)
- row_border_we  out  1  row border RAM write strobe
- row_border_waddr  out  11  2k = low line, 2k+1 = high line of row k
- row_border_wdata  out  11  line index
- col_border_we  out  1  column border RAM write strobe
- col_border_waddr  out  11  2k = left pixel, 2k+1 = right pixel of column k
- col_border_wdata  out  11  pixel index
- frame_cnt  out  2  0 = row projection, 1 = column projection, 2 = recognition frame
- num_row  out  4  rows found (saturating)
- num_col  out  4  columns found (saturating)
- project_done_flag  out  1  borders valid; high from scan end through end of frame 2
- proj_ovf  out  1  sticky: more runs detected than NUM_ROW/NUM_COL

Behaviour:
- **Reset** (`rst` high at clk edge): state IDLE. All outputs 0, `proj_ovf` 0, column bitmap cleared. Reset mid-frame abandons all work; no further writes until the next `start`.
- **Frame markers:**
  - frame start (fs) = `frame_de` && `xpos`==0 && `ypos`==0
  - line end (le) = `frame_de` && `ypos`==H_PIXEL-1
  - frame end (fe) = le && `xpos`==V_PIXEL-1
- **States:** IDLE → WAIT_FS → ROW_PROJ → COL_PROJ → COL_SCAN → DONE → WAIT_FS (loops until reset).
- **IDLE:** on `start` go to WAIT_FS. `start` is ignored in all other states.
- **WAIT_FS:** on fs go to ROW_PROJ, `frame_cnt`=0, `num_row`=`num_col`=0, `project_done_flag`=0. The fs pixel itself is processed.
- **ROW_PROJ:**
  - `line_hit` = OR of (`frame_de` & ~`monoc`) over the line; `prev_hit` = previous line's `line_hit`.
  - At le with `line_hit` (including the le pixel) && !`prev_hit`: one cycle later `row_border_we`=1, addr=2*`num_row`, data=`xpos`.
  - At le with !`line_hit` && `prev_hit`: one cycle later we=1, addr=2*`num_row`+1, data=`xpos`-1; then `num_row`++.
  - Run still open at fe: close it with data=V_PIXEL-1.
  - Runs beyond NUM_ROW: no write, count holds, `proj_ovf`=1.
  - fe → COL_PROJ, `frame_cnt`=1.
- **COL_PROJ:**
  - Bitmap `col_hit`[H_PIXEL] cleared at entry.
  - `col_hit`[`ypos`] set when `frame_de` & ~`monoc`.
  - fe → COL_SCAN.
- **COL_SCAN:**
  - Index i runs 0..H_PIXEL-1, one per cycle, same run detection over `col_hit`[i] vs `col_hit`[i-1].
  - Left edge: we=1 one cycle later, addr 2*`num_col`, data i.
  - Right edge: addr 2*`num_col`+1, data i-1, then `num_col`++.
  - Run open at i=H_PIXEL-1 closes with data H_PIXEL-1.
  - Column overflow handled as for rows.
  - Required vertical blanking ≥ H_PIXEL+4 cycles; fs arriving during scan is ignored.
  - One cycle after the final write slot: `project_done_flag`=1, go to DONE.
- **DONE:**
  - On fs: `frame_cnt`=2.
  - On fe: `project_done_flag`=0, `frame_cnt`=0, state WAIT_FS (next fs starts a fresh cycle).
- Row and column write strobes are never asserted in the same state. Each strobe is a single-cycle pulse per edge.
- Single-line / single-pixel runs give low==high. Foreground on line 0 or pixel 0 gives low/left = 0.

Test Plan:
- **Single band:** `start`; frame 0 dark lines 100..149 → writes (0,100), (1,149); `num_row`=1.
- **Seven columns:** frame 1 dark columns at 10..19, 40..49, …, 7 runs → 14 column writes ascending, `num_col`=7, `project_done_flag` rises H_PIXEL+1 cycles after fe, `frame_cnt`=2 at next fs.
- **Edge-touching glyph:** dark lines 0..3 and 760..767 with NUM_ROW=2 → (0,0), (1,3), (2,760), (3,767).
- **Overflow:** 9 column runs with NUM_COL=7 → only 14 writes, `num_col`=7, `proj_ovf`=1 sticky.
- **Reset mid-frame:** assert `rst` at line 300 of frame 0 → all outputs 0 next cycle, no writes until `start` plus a new fs.
- **Blank frame:** all `monoc`=1 → no writes, `num_row`=`num_col`=0, `project_done_flag` still asserts after scan and clears at end of frame 2.

Source files
------------

// File: rtl/digital_project.sv
// -----------------------------------------------------------------------------
// digital_project -- projection front end for the digit recogniser.
//
// Watches a binarised video stream and finds the line and pixel bounds of the
// dark glyph bands. Frame 0 is projected onto lines (row runs). Frame 1 is
// projected onto pixel columns into a bitmap. The bitmap is then scanned during
// vertical blanking. Each run produces a {low/left, high/right} pair in the
// row or column border RAM.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle arm pulse, only honoured in IDLE
//   frame_de, monoc          pixel qualifier and binarised pixel (0 = dark)
//   xpos, ypos               line index / pixel index of the current pixel
//   row_border_we/waddr/wdata  row border RAM write port
//   col_border_we/waddr/wdata  column border RAM write port
//   frame_cnt                0 row frame, 1 column frame, 2 recognition frame
//   num_row, num_col         runs recorded (held at NUM_ROW / NUM_COL)
//   project_done_flag        border RAMs valid (scan end .. end of frame 2)
//   proj_ovf                 sticky: more runs seen than could be recorded
// -----------------------------------------------------------------------------
module digital_project #(
    parameter int NUM_ROW = 1,
    parameter int NUM_COL = 7,
    parameter int H_PIXEL = 1024,
    parameter int V_PIXEL = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        frame_de,
    input  logic        monoc,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic        row_border_we,
    output logic [10:0] row_border_waddr,
    output logic [10:0] row_border_wdata,
    output logic        col_border_we,
    output logic [10:0] col_border_waddr,
    output logic [10:0] col_border_wdata,
    output logic [1:0]  frame_cnt,
    output logic [3:0]  num_row,
    output logic [3:0]  num_col,
    output logic        project_done_flag,
    output logic        proj_ovf
);

    localparam int               IDX_W     = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;
    localparam logic [10:0]      H_LAST    = 11'(H_PIXEL - 1);
    localparam logic [10:0]      V_LAST    = 11'(V_PIXEL - 1);
    localparam logic [10:0]      H_SIZE    = 11'(H_PIXEL);
    localparam logic [3:0]       ROW_LIM   = 4'(NUM_ROW);
    localparam logic [3:0]       COL_LIM   = 4'(NUM_COL);
    localparam logic [IDX_W-1:0] SCAN_LAST = IDX_W'(H_PIXEL - 1);
    localparam logic [IDX_W-1:0] SCAN_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FS,
        ST_ROW_PROJ,
        ST_COL_PROJ,
        ST_COL_SCAN,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic               line_hit_q;
    logic               prev_hit_q;
    logic [H_PIXEL-1:0] col_hit_q;
    logic [IDX_W-1:0]   scan_idx_q;
    logic               scan_flush_q;
    logic               col_prev_q;
    logic               pend_close_q;
    logic               row_we_q;
    logic [10:0]        row_waddr_q;
    logic [10:0]        row_wdata_q;
    logic               col_we_q;
    logic [10:0]        col_waddr_q;
    logic [10:0]        col_wdata_q;
    logic [1:0]         frame_cnt_q;
    logic [3:0]         num_row_q;
    logic [3:0]         num_col_q;
    logic               done_q;
    logic               ovf_q;

    logic        fs_s, le_s, fe_s, dark_s, row_cur_s, col_cur_s, scan_end_s;
    logic        ev_s, cur_s, prev_s, last_s, room_s;
    logic [10:0] pos_s;
    logic [3:0]  cnt_s, lim_s;
    logic        wr_s, inc_s, ovf_set_s, pend_set_s;
    logic [10:0] waddr_s, wdata_s;

    assign fs_s       = frame_de && (xpos == 11'd0) && (ypos == 11'd0);
    assign le_s       = frame_de && (ypos == H_LAST);
    assign fe_s       = le_s && (xpos == V_LAST);
    assign dark_s     = frame_de && !monoc;
    // The current pixel counts toward its own line, including the le pixel.
    assign row_cur_s  = line_hit_q | dark_s;
    assign col_cur_s  = col_hit_q[scan_idx_q];
    assign scan_end_s = (scan_idx_q == SCAN_LAST);
    assign room_s     = (cnt_s < lim_s);

    // Present either the line projection or the bitmap scan to one run detector.
    always_comb begin
        ev_s   = 1'b0;
        cur_s  = 1'b0;
        prev_s = 1'b0;
        last_s = 1'b0;
        pos_s  = 11'd0;
        cnt_s  = 4'd0;
        lim_s  = 4'd0;
        if (state_q == ST_ROW_PROJ) begin
            ev_s   = le_s;
            cur_s  = row_cur_s;
            prev_s = prev_hit_q;
            last_s = fe_s;
            pos_s  = xpos;
            cnt_s  = num_row_q;
            lim_s  = ROW_LIM;
        end else if (state_q == ST_COL_SCAN) begin
            ev_s   = !scan_flush_q;
            cur_s  = col_cur_s;
            prev_s = col_prev_q;
            last_s = scan_end_s;
            pos_s  = 11'(scan_idx_q);
            cnt_s  = num_col_q;
            lim_s  = COL_LIM;
        end else begin
            ev_s   = 1'b0;
        end
    end

    // Run edge decisions. A run opening on the last position needs a second
    // write slot for its high edge, which is flagged as a pending close.
    always_comb begin
        wr_s       = 1'b0;
        inc_s      = 1'b0;
        ovf_set_s  = 1'b0;
        pend_set_s = 1'b0;
        waddr_s    = 11'd0;
        wdata_s    = 11'd0;
        if (ev_s && cur_s && !prev_s) begin
            if (room_s) begin
                wr_s       = 1'b1;
                waddr_s    = {6'd0, cnt_s, 1'b0};
                wdata_s    = pos_s;
                pend_set_s = last_s;
            end else begin
                ovf_set_s  = 1'b1;
            end
        end else if (ev_s && !cur_s && prev_s) begin
            if (room_s) begin
                wr_s    = 1'b1;
                inc_s   = 1'b1;
                waddr_s = {6'd0, cnt_s, 1'b1};
                wdata_s = pos_s - 11'd1;
            end else begin
                wr_s    = 1'b0;
            end
        end else if (ev_s && cur_s && prev_s && last_s) begin
            if (room_s) begin
                wr_s    = 1'b1;
                inc_s   = 1'b1;
                waddr_s = {6'd0, cnt_s, 1'b1};
                wdata_s = pos_s;
            end else begin
                wr_s    = 1'b0;
            end
        end else begin
            wr_s = 1'b0;
        end
    end

    // Projection state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            line_hit_q   <= 1'b0;
            prev_hit_q   <= 1'b0;
            col_hit_q    <= '0;
            scan_idx_q   <= '0;
            scan_flush_q <= 1'b0;
            col_prev_q   <= 1'b0;
            pend_close_q <= 1'b0;
            row_we_q     <= 1'b0;
            row_waddr_q  <= 11'd0;
            row_wdata_q  <= 11'd0;
            col_we_q     <= 1'b0;
            col_waddr_q  <= 11'd0;
            col_wdata_q  <= 11'd0;
            frame_cnt_q  <= 2'd0;
            num_row_q    <= 4'd0;
            num_col_q    <= 4'd0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            row_we_q <= 1'b0;
            col_we_q <= 1'b0;
            if (ovf_set_s) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_WAIT_FS;
                    end
                end
                ST_WAIT_FS: begin
                    if (fs_s) begin
                        state_q      <= ST_ROW_PROJ;
                        frame_cnt_q  <= 2'd0;
                        num_row_q    <= 4'd0;
                        num_col_q    <= 4'd0;
                        done_q       <= 1'b0;
                        line_hit_q   <= dark_s;
                        prev_hit_q   <= 1'b0;
                        pend_close_q <= 1'b0;
                    end
                end
                ST_ROW_PROJ: begin
                    if (le_s) begin
                        prev_hit_q <= row_cur_s;
                        line_hit_q <= 1'b0;
                    end else begin
                        line_hit_q <= row_cur_s;
                    end
                    if (wr_s) begin
                        row_we_q    <= 1'b1;
                        row_waddr_q <= waddr_s;
                        row_wdata_q <= wdata_s;
                    end
                    if (inc_s) begin
                        num_row_q <= num_row_q + 4'd1;
                    end
                    if (fe_s) begin
                        state_q      <= ST_COL_PROJ;
                        frame_cnt_q  <= 2'd1;
                        col_hit_q    <= '0;
                        pend_close_q <= pend_set_s;
                    end
                end
                ST_COL_PROJ: begin
                    // A single-line run on the last line closes here.
                    if (pend_close_q) begin
                        row_we_q     <= 1'b1;
                        row_waddr_q  <= {6'd0, num_row_q, 1'b1};
                        row_wdata_q  <= V_LAST;
                        num_row_q    <= num_row_q + 4'd1;
                        pend_close_q <= 1'b0;
                    end
                    if (dark_s && (ypos < H_SIZE)) begin
                        col_hit_q[ypos[IDX_W-1:0]] <= 1'b1;
                    end
                    if (fe_s) begin
                        state_q      <= ST_COL_SCAN;
                        scan_idx_q   <= '0;
                        scan_flush_q <= 1'b0;
                        col_prev_q   <= 1'b0;
                    end
                end
                ST_COL_SCAN: begin
                    if (!scan_flush_q) begin
                        col_prev_q <= col_cur_s;
                        if (wr_s) begin
                            col_we_q    <= 1'b1;
                            col_waddr_q <= waddr_s;
                            col_wdata_q <= wdata_s;
                        end
                        if (inc_s) begin
                            num_col_q <= num_col_q + 4'd1;
                        end
                        if (scan_end_s) begin
                            scan_flush_q <= 1'b1;
                            pend_close_q <= pend_set_s;
                        end else begin
                            scan_idx_q <= scan_idx_q + SCAN_ONE;
                        end
                    end else begin
                        // Final slot: pending single-pixel close, then publish.
                        if (pend_close_q) begin
                            col_we_q     <= 1'b1;
                            col_waddr_q  <= {6'd0, num_col_q, 1'b1};
                            col_wdata_q  <= H_LAST;
                            num_col_q    <= num_col_q + 4'd1;
                            pend_close_q <= 1'b0;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (fe_s) begin
                        done_q      <= 1'b0;
                        frame_cnt_q <= 2'd0;
                        state_q     <= ST_WAIT_FS;
                    end else if (fs_s) begin
                        frame_cnt_q <= 2'd2;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign row_border_we     = row_we_q;
    assign row_border_waddr  = row_waddr_q;
    assign row_border_wdata  = row_wdata_q;
    assign col_border_we     = col_we_q;
    assign col_border_waddr  = col_waddr_q;
    assign col_border_wdata  = col_wdata_q;
    assign frame_cnt         = frame_cnt_q;
    assign num_row           = num_row_q;
    assign num_col           = num_col_q;
    assign project_done_flag = done_q;
    assign proj_ovf          = ovf_q;

endmodule

// File: tb/tb_digital_project.sv
// -----------------------------------------------------------------------------
// tb_digital_project -- scoreboard bench for digital_project on a reduced
// 32x24 raster. Frame images are generated and the expected border writes are
// derived from them by finding runs of dark lines / dark columns; a monitor
// pops and compares every strobe the DUT produces.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_digital_project;

    localparam int H      = 32;
    localparam int V      = 24;
    localparam int NR     = 2;
    localparam int NC     = 7;
    localparam int HBLANK = 2;
    localparam int VBLANK = H + 8;

    logic        clk = 1'b0;
    logic        rst, start, frame_de, monoc;
    logic [10:0] xpos, ypos;
    logic        row_border_we, col_border_we;
    logic [10:0] row_border_waddr, row_border_wdata;
    logic [10:0] col_border_waddr, col_border_wdata;
    logic [1:0]  frame_cnt;
    logic [3:0]  num_row, num_col;
    logic        project_done_flag, proj_ovf;

    typedef struct packed {
        logic [10:0] addr;
        logic [10:0] data;
    } wr_t;

    wr_t         row_q[$];
    wr_t         col_q[$];
    logic [H-1:0] img0 [V];
    logic [H-1:0] img1 [V];
    logic [H-1:0] img2 [V];
    int          exp_num_row, exp_num_col;
    logic        exp_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    digital_project #(
        .NUM_ROW(NR), .NUM_COL(NC), .H_PIXEL(H), .V_PIXEL(V)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_de(frame_de), .monoc(monoc),
        .xpos(xpos), .ypos(ypos),
        .row_border_we(row_border_we), .row_border_waddr(row_border_waddr),
        .row_border_wdata(row_border_wdata),
        .col_border_we(col_border_we), .col_border_waddr(col_border_waddr),
        .col_border_wdata(col_border_wdata),
        .frame_cnt(frame_cnt), .num_row(num_row), .num_col(num_col),
        .project_done_flag(project_done_flag), .proj_ovf(proj_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of its scoreboard queue.
    always @(negedge clk) begin
        wr_t e;
        if (row_border_we === 1'b1) begin
            if (row_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL row_write_unexpected: got addr %0d data %0d, expected no write",
                         row_border_waddr, row_border_wdata);
            end else begin
                e = row_q.pop_front();
                check("row_addr", 32'(row_border_waddr), 32'(e.addr));
                check("row_data", 32'(row_border_wdata), 32'(e.data));
            end
        end
        if (col_border_we === 1'b1) begin
            if (col_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL col_write_unexpected: got addr %0d data %0d, expected no write",
                         col_border_waddr, col_border_wdata);
            end else begin
                e = col_q.pop_front();
                check("col_addr", 32'(col_border_waddr), 32'(e.addr));
                check("col_data", 32'(col_border_wdata), 32'(e.data));
            end
        end
    end

    // Reference: runs of lines containing any dark pixel in frame 0.
    task automatic model_rows();
        int  lo, hi, k;
        bit  in_run, hit;
        in_run = 0;
        k = 0;
        lo = 0;
        for (int v = 0; v < V; v++) begin
            hit = |img0[v];
            if (hit && !in_run) begin
                in_run = 1;
                lo = v;
            end
            if (in_run && (!hit || v == V - 1)) begin
                hi = hit ? v : v - 1;
                if (k < NR) begin
                    row_q.push_back(wr_t'{11'(2 * k), 11'(lo)});
                    row_q.push_back(wr_t'{11'(2 * k + 1), 11'(hi)});
                end
                k++;
                in_run = 0;
            end
        end
        exp_num_row = (k < NR) ? k : NR;
        if (k > NR) exp_ovf = 1'b1;
    endtask

    // Reference: runs of pixel columns containing any dark pixel in frame 1.
    task automatic model_cols();
        int  lo, hi, k;
        bit  in_run, hit;
        in_run = 0;
        k = 0;
        lo = 0;
        for (int y = 0; y < H; y++) begin
            hit = 0;
            for (int v = 0; v < V; v++) hit = hit | img1[v][y];
            if (hit && !in_run) begin
                in_run = 1;
                lo = y;
            end
            if (in_run && (!hit || y == H - 1)) begin
                hi = hit ? y : y - 1;
                if (k < NC) begin
                    col_q.push_back(wr_t'{11'(2 * k), 11'(lo)});
                    col_q.push_back(wr_t'{11'(2 * k + 1), 11'(hi)});
                end
                k++;
                in_run = 0;
            end
        end
        exp_num_col = (k < NC) ? k : NC;
        if (k > NC) exp_ovf = 1'b1;
    endtask

    function automatic logic [H-1:0] line_of(input int which, input int v);
        if (which == 0) return img0[v];
        else if (which == 1) return img1[v];
        else return img2[v];
    endfunction

    task automatic clear_imgs();
        for (int v = 0; v < V; v++) begin
            img0[v] = '0;
            img1[v] = '0;
            img2[v] = H'($urandom);
        end
    endtask

    task automatic row_band(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) img0[v][$urandom_range(H - 1, 0)] = 1'b1;
    endtask

    task automatic col_band(input int lo, input int hi);
        for (int y = lo; y <= hi; y++) img1[$urandom_range(V - 1, 0)][y] = 1'b1;
    endtask

    task automatic random_imgs();
        for (int v = 0; v < V; v++)
            if ($urandom_range(2, 0) == 0) img0[v] = H'($urandom) | (H'(1) << $urandom_range(H - 1, 0));
        for (int y = 0; y < H; y++)
            if ($urandom_range(2, 0) == 0) img1[$urandom_range(V - 1, 0)][y] = 1'b1;
    endtask

    task automatic drive_px(input logic de, input logic mono, input int x, input int y);
        @(negedge clk);
        frame_de = de;
        monoc    = mono;
        xpos     = 11'(x);
        ypos     = 11'(y);
    endtask

    task automatic blank_px();
        drive_px(1'b0, 1'($urandom), $urandom_range(2047, 0), $urandom_range(2047, 0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_row_we"},  32'(row_border_we), 0);
        check({tag, "_row_adr"}, 32'(row_border_waddr), 0);
        check({tag, "_row_dat"}, 32'(row_border_wdata), 0);
        check({tag, "_col_we"},  32'(col_border_we), 0);
        check({tag, "_col_adr"}, 32'(col_border_waddr), 0);
        check({tag, "_col_dat"}, 32'(col_border_wdata), 0);
        check({tag, "_fcnt"},    32'(frame_cnt), 0);
        check({tag, "_nrow"},    32'(num_row), 0);
        check({tag, "_ncol"},    32'(num_col), 0);
        check({tag, "_done"},    32'(project_done_flag), 0);
        check({tag, "_ovf"},     32'(proj_ovf), 0);
    endtask

    // One frame plus blanking. Output samples at index b of the vertical
    // blanking are b cycles after the fe pixel was presented.
    task automatic drive_frame(input int which, input int fc_fs, input int done_fs,
                               input int fc_after, input bit scan_chk, input int rst_line);
        logic [H-1:0] ln;
        for (int v = 0; v < V; v++) begin
            ln = line_of(which, v);
            for (int y = 0; y < H; y++) begin
                drive_px(1'b1, ~ln[y], v, y);
                if (v == rst_line && y == 0) rst = 1'b1;
                if (v == rst_line && y == 1) begin
                    rst = 1'b0;
                    check_zero("midrst");
                end
                if (v == 0 && y == 1) begin
                    check("fcnt_at_fs", 32'(frame_cnt), 32'(fc_fs));
                    check("done_at_fs", 32'(project_done_flag), 32'(done_fs));
                end
            end
            if (v < V - 1) for (int b = 0; b < HBLANK; b++) blank_px();
        end
        for (int b = 1; b <= VBLANK; b++) begin
            blank_px();
            if (b == 2) begin
                check("fcnt_after_fe", 32'(frame_cnt), 32'(fc_after));
                check("done_after_fe", 32'(project_done_flag), 0);
            end
            if (scan_chk && b == H + 1) check("done_before_scan_end", 32'(project_done_flag), 0);
            if (scan_chk && b == H + 2) check("done_at_scan_end", 32'(project_done_flag), 1);
        end
    endtask

    task automatic run_cycle();
        model_rows();
        model_cols();
        drive_frame(0, 0, 0, 1, 1'b0, -1);
        drive_frame(1, 1, 0, 1, 1'b1, -1);
        check("row_writes_missing", 32'(row_q.size()), 0);
        check("col_writes_missing", 32'(col_q.size()), 0);
        check("num_row", 32'(num_row), 32'(exp_num_row));
        check("num_col", 32'(num_col), 32'(exp_num_col));
        check("proj_ovf", 32'(proj_ovf), 32'(exp_ovf));
        drive_frame(2, 2, 1, 0, 1'b0, -1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        frame_de = 1'b0;
        monoc = 1'b1;
        xpos = 11'd0;
        ypos = 11'd0;
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Frame while idle must not start anything.
        clear_imgs();
        row_band(5, 8);
        drive_frame(0, 0, 0, 0, 1'b0, -1);
        pulse_start();

        // Single band, seven column runs.
        clear_imgs();
        row_band(10, 14);
        for (int k = 0; k < 7; k++) col_band(1 + 4 * k, 2 + 4 * k);
        run_cycle();

        // Edge-touching runs.
        clear_imgs();
        row_band(0, 3);
        row_band(20, 23);
        col_band(0, 1);
        col_band(31, 31);
        run_cycle();

        // Single-line / single-pixel runs on both boundaries.
        clear_imgs();
        row_band(0, 0);
        row_band(23, 23);
        col_band(0, 0);
        col_band(30, 31);
        run_cycle();

        // Overflow on both axes.
        clear_imgs();
        row_band(0, 1);
        row_band(5, 6);
        row_band(10, 12);
        for (int k = 0; k < 9; k++) col_band(3 * k, 3 * k);
        run_cycle();

        // Blank frames; overflow stays set.
        clear_imgs();
        run_cycle();

        for (int n = 0; n < 6; n++) begin
            clear_imgs();
            random_imgs();
            run_cycle();
        end

        // Reset in the middle of frame 0: first band written, second abandoned.
        clear_imgs();
        row_band(4, 6);
        model_rows();
        row_band(14, 16);
        exp_ovf = 1'b0;
        drive_frame(0, 0, 0, 0, 1'b0, 10);
        check("rst_row_q_empty", 32'(row_q.size()), 0);
        drive_frame(0, 0, 0, 0, 1'b0, -1);
        check("rst_stays_idle_nrow", 32'(num_row), 0);

        pulse_start();
        clear_imgs();
        random_imgs();
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
